// File: rtl/audio_pkg.sv
// Shared types and constants for the audio controller: mode encoding, bus widths,
// speed-level limits and command-key arbitration.
package audio_pkg;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LVL_W  = 4;

  localparam logic [LVL_W-1:0]  SPEED_NORMAL = 4'd7;
  localparam logic [LVL_W-1:0]  SPEED_MAX    = 4'd14;
  localparam logic [ADDR_W-1:0] ADDR_LAST    = '1;

  typedef enum logic [1:0] {
    ModeIdle   = 2'd0,
    ModeRecord = 2'd1,
    ModePlay   = 2'd2,
    ModePause  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    KeyNone,
    KeyStop,
    KeyRecord,
    KeyPlay,
    KeyPause
  } key_e;

  // Only the highest-priority key survives; the FSM ignores it if it does not apply.
  function automatic key_e resolve_key(input logic stop, input logic record,
                                       input logic play, input logic pause);
    if (stop)        return KeyStop;
    else if (record) return KeyRecord;
    else if (play)   return KeyPlay;
    else if (pause)  return KeyPause;
    else             return KeyNone;
  endfunction

endpackage

// File: rtl/speed_map.sv
// Combinational map from speed level (0..14) to player slow/fast step factors.
module speed_map
  import audio_pkg::*;
(
  input  logic [LVL_W-1:0] lvl,
  output logic [3:0]       slow,
  output logic [3:0]       fast
);

  always_comb begin
    slow = 4'd1;
    fast = 4'd1;
    if (lvl > SPEED_NORMAL) begin
      fast = lvl - 4'd6;
    end else if (lvl < SPEED_NORMAL) begin
      slow = 4'd8 - lvl;
    end
  end

endmodule

// File: rtl/audio_ctrl.sv
// Record/play/pause controller with SRAM arbitration and frame-aligned speed control.
// Define AUDIO_CTRL_AUTOLOOP_EN to restart playback from address 0 instead of stopping.
module audio_ctrl
  import audio_pkg::*;
(
  input  logic              bclk,
  input  logic              rst_n,
  input  logic              key_record,
  input  logic              key_play,
  input  logic              key_pause,
  input  logic              key_stop,
  input  logic              key_faster,
  input  logic              key_slower,
  input  logic              interp_sel,
  input  logic              daclrc,
  input  logic [ADDR_W-1:0] play_addr,
  input  logic [ADDR_W-1:0] rec_addr,
  input  logic              rec_req,
  input  logic [DATA_W-1:0] rec_data,
  output logic              play,
  output logic              stop,
  output logic              record,
  output logic [3:0]        slow,
  output logic [3:0]        fast,
  output logic              slowmethod,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic [DATA_W-1:0] sram_dq,
  output logic              sram_dq_oe,
  output logic [1:0]        mode,
  output logic [ADDR_W-1:0] end_addr
);

  mode_e             state_q, state_d;
  key_e              key;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic [3:0]        slow_q, fast_q, slow_map, fast_map;
  logic              slowmethod_q;
  logic [ADDR_W-1:0] end_addr_q, waddr_q;
  logic [DATA_W-1:0] dq_q;
  logic              we_n_q, dq_oe_q, daclrc_q;
  logic              daclrc_rise, wr_accept, play_end, loop_stop;

  assign key         = resolve_key(key_stop, key_record, key_play, key_pause);
  assign daclrc_rise = daclrc & ~daclrc_q;
  // A stop in the same cycle as a request aborts the write before it reaches the pins.
  assign wr_accept   = (state_q == ModeRecord) && rec_req && !key_stop;
  assign play_end    = daclrc_rise && (play_addr >= end_addr_q);

  speed_map u_speed_map (
    .lvl  (lvl_q),
    .slow (slow_map),
    .fast (fast_map)
  );

  always_comb begin
    lvl_d = lvl_q;
    if (key_faster && !key_slower && lvl_q != SPEED_MAX) begin
      lvl_d = lvl_q + 4'd1;
    end else if (key_slower && !key_faster && lvl_q != '0) begin
      lvl_d = lvl_q - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ModeIdle: begin
        if (key == KeyRecord)    state_d = ModeRecord;
        else if (key == KeyPlay) state_d = ModePlay;
      end
      ModeRecord: begin
        if (key == KeyStop)                            state_d = ModeIdle;
        else if (wr_accept && rec_addr == ADDR_LAST)   state_d = ModeIdle;
      end
      ModePlay: begin
        if (key == KeyStop)       state_d = ModeIdle;
        else if (key == KeyPause) state_d = ModePause;
`ifndef AUDIO_CTRL_AUTOLOOP_EN
        else if (play_end)        state_d = ModeIdle;
`endif
      end
      ModePause: begin
        if (key == KeyStop)      state_d = ModeIdle;
        else if (key == KeyPlay) state_d = ModePlay;
      end
      default: state_d = ModeIdle;
    endcase
  end

`ifdef AUDIO_CTRL_AUTOLOOP_EN
  logic loop_q;

  always_ff @(negedge bclk) begin
    if (!rst_n) begin
      loop_q <= 1'b0;
    end else begin
      loop_q <= (state_q == ModePlay) && (state_d == ModePlay) && (key == KeyNone) && play_end;
    end
  end

  assign loop_stop = loop_q && (state_q == ModePlay);
`else
  assign loop_stop = 1'b0;
`endif

  always_ff @(negedge bclk) begin
    if (!rst_n) begin
      state_q      <= ModeIdle;
      lvl_q        <= SPEED_NORMAL;
      slow_q       <= 4'd1;
      fast_q       <= 4'd1;
      slowmethod_q <= 1'b0;
      end_addr_q   <= '0;
      waddr_q      <= '0;
      dq_q         <= '0;
      we_n_q       <= 1'b1;
      dq_oe_q      <= 1'b0;
      daclrc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      lvl_q    <= lvl_d;
      daclrc_q <= daclrc;
      we_n_q   <= ~wr_accept;
      dq_oe_q  <= wr_accept;
      if (wr_accept) begin
        dq_q       <= rec_data;
        waddr_q    <= rec_addr;
        end_addr_q <= rec_addr;
      end
      // Speed changes land only on frame boundaries so the player never splits a frame.
      if (daclrc_rise) begin
        slow_q       <= slow_map;
        fast_q       <= fast_map;
        slowmethod_q <= interp_sel && (lvl_q < SPEED_NORMAL);
      end
    end
  end

  always_comb begin
    play      = 1'b0;
    stop      = 1'b1;
    record    = 1'b0;
    sram_oe_n = 1'b1;
    sram_addr = '0;
    unique case (state_q)
      ModeIdle: ;
      ModeRecord: begin
        record    = 1'b1;
        sram_addr = rec_addr;
      end
      ModePlay: begin
        play      = 1'b1;
        stop      = loop_stop;
        sram_oe_n = 1'b0;
        sram_addr = loop_stop ? '0 : play_addr;
      end
      ModePause: begin
        stop      = 1'b0;
        sram_oe_n = 1'b0;
        sram_addr = play_addr;
      end
      default: ;
    endcase
    // A registered write keeps its own address, even if the FSM has just left RECORD.
    if (!we_n_q) sram_addr = waddr_q;
  end

  assign sram_we_n  = we_n_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_dq    = dq_q;
  assign slow       = slow_q;
  assign fast       = fast_q;
  assign slowmethod = slowmethod_q;
  assign mode       = state_q;
  assign end_addr   = end_addr_q;

endmodule
